firebird7_in_gate1_tessent_msib: RTL



---
 rtl/firebird7_in_gate1_tessent_msib_pkg.sv | 29 ++
 rtl/firebird7_in_gate1_tessent_msib_cell.sv | 68 ++++++
 rtl/firebird7_in_gate1_tessent_msib.sv | 78 +++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tessent_msib_pkg.sv
// Shared types and helpers for the gate1 multi-segment SIB.
// Capture of per-segment status is enabled by FIREBIRD7_MSIB_CAPTURE_STATUS_EN.
package firebird7_in_gate1_tessent_msib_pkg;

   localparam int MSIB_MAX_SEG = 16;
   localparam int MSIB_LEN_W   = 8;

   typedef logic [MSIB_MAX_SEG-1:0] msib_vec_t;
   typedef logic [MSIB_MAX_SEG-1:0][MSIB_LEN_W-1:0] msib_len_t;

   typedef enum logic [1:0] {
      MSIB_HOLD    = 2'd0,
      MSIB_CAPTURE = 2'd1,
      MSIB_SHIFT   = 2'd2
   } msib_op_e;

   // Host path length: one SIB bit per segment plus every open child chain.
   function automatic int unsigned msib_path_len(input msib_vec_t   open_mask,
                                                 input msib_len_t   child_len,
                                                 input int unsigned num_seg);
      int unsigned n;
      n = num_seg;
      for (int k = 0; k < MSIB_MAX_SEG; k++) begin
         if ((k < int'(num_seg)) && open_mask[k]) n += int'(child_len[k]);
      end
      return n;
   endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_msib_cell.sv
// One MSIB bit: shift stage (posedge), update and enable stages (negedge),
// the child splice mux and the child select gate.
module firebird7_in_gate1_tessent_msib_cell
   import firebird7_in_gate1_tessent_msib_pkg::*;
#(
   parameter logic RESET_OPEN = 1'b0
) (
   input  logic tck_i,
   input  logic rst_ni,
   input  logic sel_i,
   input  logic ce_i,
   input  logic se_i,
   input  logic ue_i,
   input  logic prev_i,
   input  logic from_so_i,
   input  logic cap_i,
   output logic sib_o,
   output logic to_si_o,
   output logic to_sel_o
);

   logic     sib_q, sib_d;
   logic     upd_q, upd_d;
   logic     en_q;
   msib_op_e op;

   // Capture outranks shift when both are requested.
   always_comb begin
      op = MSIB_HOLD;
      if (sel_i && ce_i)      op = MSIB_CAPTURE;
      else if (sel_i && se_i) op = MSIB_SHIFT;
   end

   always_comb begin
      sib_d = sib_q;
      case (op)
         MSIB_CAPTURE: sib_d = cap_i;
         MSIB_SHIFT:   sib_d = upd_q ? from_so_i : prev_i;
         default:      sib_d = sib_q;
      endcase
   end

   always_comb begin
      upd_d = upd_q;
      if (sel_i && ue_i) upd_d = sib_q;
   end

   always_ff @(posedge tck_i or negedge rst_ni) begin
      if (!rst_ni) sib_q <= 1'b0;
      else         sib_q <= sib_d;
   end

   // en trails upd by one falling edge so child select changes a full tck later.
   always_ff @(negedge tck_i or negedge rst_ni) begin
      if (!rst_ni) begin
         upd_q <= RESET_OPEN;
         en_q  <= RESET_OPEN;
      end else begin
         upd_q <= upd_d;
         en_q  <= upd_q;
      end
   end

   assign sib_o    = sib_q;
   assign to_si_o  = prev_i;
   assign to_sel_o = sel_i & en_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_msib.sv
// Multi-segment SIB top: NUM_SEG cells chained on the host path, retimed scan out.
// Define FIREBIRD7_MSIB_CAPTURE_STATUS_EN to capture ijtag_status instead of zero.
module firebird7_in_gate1_tessent_msib
   import firebird7_in_gate1_tessent_msib_pkg::*;
#(
   parameter int                 NUM_SEG    = 4,
   parameter logic [NUM_SEG-1:0] RESET_OPEN = '0
) (
   input  logic               ijtag_tck,
   input  logic               ijtag_reset,
   input  logic               ijtag_sel,
   input  logic               ijtag_si,
   input  logic               ijtag_ce,
   input  logic               ijtag_se,
   input  logic               ijtag_ue,
   output logic               ijtag_so,
   input  logic [NUM_SEG-1:0] ijtag_from_so,
   input  logic [NUM_SEG-1:0] ijtag_status,
   output logic [NUM_SEG-1:0] ijtag_to_si,
   output logic [NUM_SEG-1:0] ijtag_to_sel,
   output logic               ijtag_to_ce,
   output logic               ijtag_to_se,
   output logic               ijtag_to_ue,
   output logic               ijtag_to_reset,
   output logic               ijtag_to_tck
);

   logic [NUM_SEG-1:0] sib;
   logic [NUM_SEG-1:0] prev;
   logic [NUM_SEG-1:0] cap;
   logic               so_ret_q;

`ifdef FIREBIRD7_MSIB_CAPTURE_STATUS_EN
   assign cap = ijtag_status;
`else
   logic unused_status;
   assign unused_status = ^ijtag_status;
   assign cap           = '0;
`endif

   assign prev[0] = ijtag_si;

   for (genvar k = 1; k < NUM_SEG; k++) begin : g_prev
      assign prev[k] = sib[k-1];
   end

   for (genvar k = 0; k < NUM_SEG; k++) begin : g_cell
      firebird7_in_gate1_tessent_msib_cell #(
         .RESET_OPEN (RESET_OPEN[k])
      ) u_cell (
         .tck_i     (ijtag_tck),
         .rst_ni    (ijtag_reset),
         .sel_i     (ijtag_sel),
         .ce_i      (ijtag_ce),
         .se_i      (ijtag_se),
         .ue_i      (ijtag_ue),
         .prev_i    (prev[k]),
         .from_so_i (ijtag_from_so[k]),
         .cap_i     (cap[k]),
         .sib_o     (sib[k]),
         .to_si_o   (ijtag_to_si[k]),
         .to_sel_o  (ijtag_to_sel[k])
      );
   end

   // Transparent while tck is low: scan out changes half a cycle after the shift edge.
   always_latch begin
      if (!ijtag_tck) so_ret_q <= sib[NUM_SEG-1];
   end

   assign ijtag_so       = so_ret_q;
   assign ijtag_to_ce    = ijtag_ce;
   assign ijtag_to_se    = ijtag_se;
   assign ijtag_to_ue    = ijtag_ue;
   assign ijtag_to_reset = ijtag_reset;
   assign ijtag_to_tck   = ijtag_tck;

endmodule
